// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver: segment codes and width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low gfedcba codes, indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Counter/index width that never collapses to zero bits
  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Host-side value/control inputs and board-side display outputs of the scan driver.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned IDX_W = seg7_pkg::width_min1(DIGITS);

  logic [4*DIGITS-1:0] val;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                lz;
  logic                load;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic [IDX_W-1:0]    digit_idx;
  logic                frame_start;

  modport master (
    output val, dp_in, blank_in, lz, load,
    input  seg, dp, an, digit_idx, frame_start
  );

  modport slave (
    input  val, dp_in, blank_in, lz, load,
    output seg, dp, an, digit_idx, frame_start
  );

endinterface

// File: rtl/seg7dec.sv
// Combinational hex-to-7-segment decoder, active-low gfedcba.
module seg7dec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_c
);

  assign o_seg_c = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous value update,
// leading-zero blanking and per-slot anti-ghosting dead time.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 16,
  parameter int unsigned LZ_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  localparam int unsigned IDX_W = width_min1(DIGITS);
  localparam int unsigned CNT_W = width_min1(SCAN_DIV);
  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam logic        LZ_ON = (LZ_EN != 0);

  if (SCAN_DIV < 2) begin : g_chk_div
    $error("seg7_scan: SCAN_DIV must be at least 2");
  end
  if (DEAD >= SCAN_DIV) begin : g_chk_dead
    $error("seg7_scan: DEAD must be below SCAN_DIV");
  end
  if (DIGITS < 1) begin : g_chk_digits
    $error("seg7_scan: DIGITS must be at least 1");
  end

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_wrapped;

  logic [VAL_W-1:0]  r_pend_val;
  logic [DIGITS-1:0] r_pend_dp;
  logic [DIGITS-1:0] r_pend_blank;
  logic              r_pend_lz;
  logic              r_pend;

  logic [VAL_W-1:0]  r_disp_val;
  logic [DIGITS-1:0] r_disp_dp;
  logic [DIGITS-1:0] r_disp_blank;
  logic              r_disp_lz;

  logic [6:0]        r_seg;
  logic              r_dp;
  logic [DIGITS-1:0] r_an;
  logic [IDX_W-1:0]  r_digit_idx;
  logic              r_frame_start;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_dead;
  logic              w_run;
  logic [DIGITS-1:0] w_lz_mask;
  logic [3:0]        w_nib;
  logic              w_blank_sel;
  logic              w_dp_sel;
  logic              w_lz_sel;
  logic [DIGITS-1:0] w_an_nxt;
  logic [6:0]        w_dec_seg;
  logic [6:0]        w_seg_nxt;
  logic              w_dp_nxt;

  assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
  assign w_dead      = (r_cnt < CNT_W'(DEAD));

  // Slot counter and digit index; r_wrapped marks the first cycle of a new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_wrapped <= w_frame_end;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Pending/display double buffer: display only changes on the frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_lz    <= 1'b0;
      r_pend       <= 1'b0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
      r_disp_lz    <= 1'b0;
    end else if (bus.load && w_frame_end) begin
      r_disp_val   <= bus.val;
      r_disp_dp    <= bus.dp_in;
      r_disp_blank <= bus.blank_in;
      r_disp_lz    <= bus.lz;
      r_pend       <= 1'b0;
    end else if (bus.load) begin
      r_pend_val   <= bus.val;
      r_pend_dp    <= bus.dp_in;
      r_pend_blank <= bus.blank_in;
      r_pend_lz    <= bus.lz;
      r_pend       <= 1'b1;
    end else if (w_frame_end && r_pend) begin
      r_disp_val   <= r_pend_val;
      r_disp_dp    <= r_pend_dp;
      r_disp_blank <= r_pend_blank;
      r_disp_lz    <= r_pend_lz;
      r_pend       <= 1'b0;
    end
  end

  // Leading-zero mask: walk from the most significant digit down while nibbles stay zero
  always_comb begin
    w_lz_mask = '0;
    w_run     = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      w_run = w_run & (r_disp_val[4*i +: 4] == 4'd0);
      if (i != 0) begin
        w_lz_mask[i] = w_run & r_disp_lz & LZ_ON;
      end
    end
  end

  // Select the current digit's fields and the active anode
  always_comb begin
    w_nib       = '0;
    w_blank_sel = 1'b0;
    w_dp_sel    = 1'b0;
    w_lz_sel    = 1'b0;
    w_an_nxt    = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_blank_sel = r_disp_blank[i];
        w_dp_sel    = r_disp_dp[i];
        w_lz_sel    = w_lz_mask[i];
        w_an_nxt[i] = w_dead;
      end
    end
  end

  seg7dec u_dec (
    .i_nib   (w_nib),
    .o_seg_c (w_dec_seg)
  );

  always_comb begin
    w_seg_nxt = (w_blank_sel || w_lz_sel) ? SEG_OFF : w_dec_seg;
    w_dp_nxt  = ~w_dp_sel;
  end

  // Output registers: everything visible on the pins lags cnt/idx by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_digit_idx   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_seg_nxt;
      r_dp          <= w_dp_nxt;
      r_an          <= w_an_nxt;
      r_digit_idx   <= r_idx;
      r_frame_start <= r_wrapped;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.an          = r_an;
  assign bus.digit_idx   = r_digit_idx;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIGITS=4, SCAN_DIV=4, DEAD=1, LZ_EN=1.
module tb_seg7_scan;

  localparam logic [6:0] C0   = 7'b1000000;
  localparam logic [6:0] C1   = 7'b1111001;
  localparam logic [6:0] C2   = 7'b0100100;
  localparam logic [6:0] C3   = 7'b0110000;
  localparam logic [6:0] C5   = 7'b0010010;
  localparam logic [6:0] C7   = 7'b1011000;
  localparam logic [6:0] C8   = 7'b0000000;
  localparam logic [6:0] C9   = 7'b0010000;
  localparam logic [6:0] CA   = 7'b0001000;
  localparam logic [6:0] CB   = 7'b0000011;
  localparam logic [6:0] COFF = 7'b1111111;

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [1:0] idx;
    logic       fs;
    logic [6:0] seg;
  } scan_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   passed = 0;
  int   total = 0;
  scan_vec_t tbl[$];

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(4)) bus ();

  seg7_scan #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .DEAD     (1),
    .LZ_EN    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One clock; n counts edges since reset release, outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic goto_phase(input int k);
    for (int j = 0; j < 16 && (n % 16) != k; j++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpi,
                         input logic [3:0] bl, input logic l);
    bus.val      = v;
    bus.dp_in    = dpi;
    bus.blank_in = bl;
    bus.lz       = l;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  // Sample each digit mid-slot; segs = {d3,d2,d1,d0}, dpv bit d = expected dp pin
  task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dpv);
    logic [3:0] exp_an;
    for (int d = 0; d < 4; d++) begin
      goto_phase(4*d + 3);
      exp_an = 4'b1111;
      exp_an[d] = 1'b0;
      chk($sformatf("%s.d%0d.seg", name, d), 32'(bus.seg), 32'(segs[7*d +: 7]));
      chk($sformatf("%s.d%0d.dp", name, d), 32'(bus.dp), 32'(dpv[d]));
      chk($sformatf("%s.d%0d.an", name, d), 32'(bus.an), 32'(exp_an));
      chk($sformatf("%s.d%0d.idx", name, d), 32'(bus.digit_idx), 32'(d));
    end
  endtask

  initial begin
    bus.val = '0; bus.dp_in = '0; bus.blank_in = '0; bus.lz = 1'b0; bus.load = 1'b0;

    // Reset held for 3 clocks
    tick();
    chk("rst.an", 32'(bus.an), 32'hF);
    chk("rst.seg", 32'(bus.seg), 32'(COFF));
    chk("rst.dp", 32'(bus.dp), 32'd1);
    chk("rst.idx", 32'(bus.digit_idx), 32'd0);
    chk("rst.fs", 32'(bus.frame_start), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    n = 0;

    tbl.push_back('{1,  4'b1111, 2'd0, 1'b0, C0});
    tbl.push_back('{2,  4'b1110, 2'd0, 1'b0, C0});
    tbl.push_back('{3,  4'b1110, 2'd0, 1'b0, C0});
    tbl.push_back('{4,  4'b1110, 2'd0, 1'b0, C0});
    tbl.push_back('{5,  4'b1111, 2'd1, 1'b0, C0});
    tbl.push_back('{6,  4'b1101, 2'd1, 1'b0, C0});
    tbl.push_back('{9,  4'b1111, 2'd2, 1'b0, C0});
    tbl.push_back('{10, 4'b1011, 2'd2, 1'b0, C0});
    tbl.push_back('{14, 4'b0111, 2'd3, 1'b0, C0});
    tbl.push_back('{16, 4'b0111, 2'd3, 1'b0, C0});
    tbl.push_back('{17, 4'b1111, 2'd0, 1'b1, C0});
    tbl.push_back('{18, 4'b1110, 2'd0, 1'b0, C0});
    tbl.push_back('{32, 4'b0111, 2'd3, 1'b0, C0});
    tbl.push_back('{33, 4'b1111, 2'd0, 1'b1, C0});
    tbl.push_back('{34, 4'b1110, 2'd0, 1'b0, C0});
    foreach (tbl[i]) begin
      while (n < tbl[i].n) tick();
      chk($sformatf("scan%0d.an", tbl[i].n), 32'(bus.an), 32'(tbl[i].an));
      chk($sformatf("scan%0d.idx", tbl[i].n), 32'(bus.digit_idx), 32'(tbl[i].idx));
      chk($sformatf("scan%0d.fs", tbl[i].n), 32'(bus.frame_start), 32'(tbl[i].fs));
      chk($sformatf("scan%0d.seg", tbl[i].n), 32'(bus.seg), 32'(tbl[i].seg));
    end

    // Decode: 0123, then 89AB loaded at cnt=2 idx=3 (not the boundary)
    goto_phase(5);
    do_load(16'h0123, 4'b0000, 4'b0000, 1'b0);
    check_frame("dec0123", {C0, C1, C2, C3}, 4'b1111);
    tick();
    goto_phase(14);
    do_load(16'h89AB, 4'b0000, 4'b0000, 1'b0);
    chk("dec.prebound.seg", 32'(bus.seg), 32'(C0));
    chk("dec.prebound.an", 32'(bus.an), 32'b0111);
    check_frame("dec89AB", {C8, C9, CA, CB}, 4'b1111);

    // Anti-tear: 1111 then 2222 mid-frame; old values persist, 1111 never shown
    goto_phase(3);
    chk("tear.d0", 32'(bus.seg), 32'(CB));
    goto_phase(5);
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    goto_phase(7);
    chk("tear.d1", 32'(bus.seg), 32'(CA));
    goto_phase(9);
    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    goto_phase(11);
    chk("tear.d2", 32'(bus.seg), 32'(C9));
    goto_phase(15);
    chk("tear.d3", 32'(bus.seg), 32'(C8));
    check_frame("tear2222", {C2, C2, C2, C2}, 4'b1111);

    // Boundary bypass: load exactly at cnt=3 idx=3
    tick();
    goto_phase(15);
    do_load(16'h5555, 4'b0000, 4'b0000, 1'b0);
    check_frame("byp5555a", {C5, C5, C5, C5}, 4'b1111);
    check_frame("byp5555b", {C5, C5, C5, C5}, 4'b1111);

    // Leading-zero / blank / dp
    goto_phase(5);
    do_load(16'h0070, 4'b0100, 4'b0001, 1'b1);
    check_frame("lz0070", {COFF, COFF, C7, COFF}, 4'b1011);
    goto_phase(5);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    check_frame("lz0000", {COFF, COFF, COFF, C0}, 4'b1111);
    goto_phase(5);
    do_load(16'h0070, 4'b0000, 4'b0000, 1'b0);
    check_frame("nolz0070", {C0, C0, C7, C0}, 4'b1111);

    // Reset mid-operation with a pending load at idx=2
    goto_phase(5);
    do_load(16'h8888, 4'b1111, 4'b0000, 1'b0);
    goto_phase(9);
    rst = 1'b1;
    tick();
    chk("mrst.an", 32'(bus.an), 32'hF);
    chk("mrst.seg", 32'(bus.seg), 32'(COFF));
    chk("mrst.dp", 32'(bus.dp), 32'd1);
    chk("mrst.idx", 32'(bus.digit_idx), 32'd0);
    chk("mrst.fs", 32'(bus.frame_start), 32'd0);
    tick();
    rst = 1'b0;
    n = 0;
    check_frame("mrst.f0", {C0, C0, C0, C0}, 4'b1111);
    check_frame("mrst.f1", {C0, C0, C0, C0}, 4'b1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for a common-anode, multi-digit 7-segment display.
- Takes DIGITS packed hex nibbles plus per-digit decimal-point and blank masks, and decodes one digit at a time.
- Drives shared segment lines and one anode per digit, with a programmable slot period and an anti-ghosting dead time.
- Sits between the clock/counter datapath and the board pins. New values are adopted only at frame boundaries, so the display never tears.

Parameters:
- DIGITS, 4: number of digits scanned (≥1).
- SCAN_DIV, 50000: clocks per digit slot (≥2).
- DEAD, 16: clocks at the start of each slot with all anodes off (0 ≤ DEAD < SCAN_DIV).
- LZ_EN, 1: 1 enables leading-zero blanking logic; 0 ties it off.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- val  in  4*DIGITS  hex nibbles; digit i = val[4i+3:4i]; digit 0 is rightmost
- dp_in  in  DIGITS  decimal point request per digit
- blank_in  in  DIGITS  force digit dark
- lz  in  1  leading-zero blanking request (ignored when LZ_EN=0)
- load  in  1  capture val/dp_in/blank_in/lz this cycle
- seg  out  7  segments gfedcba (seg[0]=a), active-low (0 = lit)
- dp  out  1  decimal point, active-low
- an  out  DIGITS  anode enables, active-low, one-hot-low or all-high
- digit_idx  out  $clog2(DIGITS) (min 1)  digit currently in its slot
- frame_start  out  1  one-cycle pulse when digit_idx wraps to 0

Behaviour:
- Reset (sync, active-high):
  - Internal state: cnt=0, idx=0, pending and display registers cleared, pend=0.
  - Outputs: seg=7'b1111111, dp=1, an=all 1, digit_idx=0, frame_start=0.
- Slot counter: cnt counts 0..SCAN_DIV-1 and wraps.
  - At cnt==SCAN_DIV-1, idx advances; DIGITS-1 wraps to 0.
  - frame_start=1 on the cycle after the wrap, i.e. the first cycle with idx=0.
- Load path:
  - load=1 copies the inputs into the pending registers and sets pend.
  - A later load before the boundary overwrites pending (last write wins).
- Frame boundary (cnt==SCAN_DIV-1 and idx==DIGITS-1):
  - If load=1 on this cycle, the inputs go straight to the display registers and pend stays 0.
  - Otherwise, if pend=1, pending goes to display and pend clears.
  - Otherwise display holds.
- Leading-zero mask: computed from the display registers.
  - Digit i is LZ-blanked if lz=1, LZ_EN=1, i>0, and every nibble from i up to DIGITS-1 is 0.
  - Digit 0 is never LZ-blanked.
- Per-cycle next values:
  - Dead time: if cnt<DEAD, all anodes off.
  - Otherwise an[idx]=0 and all others 1.
  - seg = decode(nibble[idx]), or 1111111 if blank_in[idx] or LZ-blanked.
  - dp = ~dp_in[idx]; a blanked digit still shows its dp.
- Output timing: seg, dp, an, digit_idx and frame_start are registered, so they lag cnt/idx by exactly 1 clock. No combinational path from inputs to outputs.
- Decode table (active-low gfedcba):

  | Nibble | Code | Nibble | Code |
  |---|---|---|---|
  | 0 | 1000000 | 8 | 0000000 |
  | 1 | 1111001 | 9 | 0010000 |
  | 2 | 0100100 | A | 0001000 |
  | 3 | 0110000 | b | 0000011 |
  | 4 | 0011001 | C | 1000110 |
  | 5 | 0010010 | d | 0100001 |
  | 6 | 0000010 | E | 0000110 |
  | 7 | 1011000 | F | 0001110 |

- DIGITS=1: idx is constant 0 and frame_start pulses every slot.
- Reset mid-slot: everything returns to reset values on the next edge; pending data is lost.
- Elaboration checks: DEAD<SCAN_DIV, SCAN_DIV≥2, DIGITS≥1.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_OFF = 7'b1111111
  - the 16-entry decode table constant
  - a width helper for idx/cnt
- One sub-module: seg7dec, the team's existing combinational hex-to-segment decoder, with the same table and active-low encoding. Instantiate it once on the muxed nibble.
- Scan counter, load/pend logic, LZ mask and output registers live in seg7_scan.

Test Plan (DIGITS=4, SCAN_DIV=4, DEAD=1, LZ_EN=1):
1. Reset/scan: rst high 3 clocks, then low.
   - While in reset: an=1111, seg=1111111, dp=1.
   - After release: an cycles 1111,1110,1110,1110 then 1111,1101,… (digit 0, then 1, 2, 3).
   - frame_start pulses every 16 clocks, coincident with digit_idx=0.
2. Decode: load val=16'h0123, then load val=16'h89AB at cnt=2, idx=3.
   - 16'h0123: seg shows 0100001? No — must show 0110000 on digit 0, 0100100 on digit 1, 1111001 on digit 2, 1000000 on digit 3.
   - Second load lands on a non-boundary cycle: no change until the boundary, then 89AB codes appear.
3. Anti-tear: load 16'h1111 at mid-frame (idx=1), then load 16'h2222 before the boundary.
   - Digits 1..3 keep the old values this frame.
   - The next frame shows only 2222; 1111 is never displayed.
4. Boundary bypass: load 16'h5555 exactly at cnt=3, idx=3 → the next frame shows 5 on all digits; pend=0.
5. LZ/blank/dp: val=16'h0070, lz=1, dp_in=4'b0100, blank_in=4'b0001.
   - Digit 3: blanked.
   - Digit 2: blanked, dp=0.
   - Digit 1: shows 1011000.
   - Digit 0: blanked by blank_in.
   - Then val=16'h0000, lz=1, blank_in=0: only digit 0 shows 1000000.
6. Reset mid-operation: assert rst at idx=2 with pend=1.
   - Next edge: an=1111, seg=1111111, digit_idx=0.
   - After release, pending data is not displayed; digits show 0 once scanning resumes.
